// File: rtl/tug_bar_if.sv
// tug_bar_if: groups the player keys, round control and the display/score
// outputs of the tug-of-war game into one bundle.
//   L, R      - left/right player keys (levels, synchronous to clk)
//   start     - new-round request (level)
//   lights    - playfield, bit NUM_LIGHTS-1 is the leftmost light
//   winner    - 00 none, 10 left, 01 right
//   score_l/r - per-player saturating win counters
// Modports: master drives keys/start (player side), slave is the game.
interface tug_bar_if #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
);
  logic                  L;
  logic                  R;
  logic                  start;
  logic [NUM_LIGHTS-1:0] lights;
  logic [1:0]            winner;
  logic [SCORE_W-1:0]    score_l;
  logic [SCORE_W-1:0]    score_r;

  modport master (
    output L, R, start,
    input  lights, winner, score_l, score_r
  );

  modport slave (
    input  L, R, start,
    output lights, winner, score_l, score_r
  );
endinterface

// File: rtl/tug_bar.sv
// tug_bar: two-player tug-of-war game. A lit dot starts in the centre of the
// playfield; each left key press pulls it one place left, each right press
// one place right. Pressing while the dot sits on your own end wins the round.
// Ports:
//   clk   - system clock, all state changes on the rising edge
//   reset - asynchronous, active-low reset (clears scores too)
//   bus   - tug_bar_if slave: L, R, start in; lights, winner, scores out
module tug_bar #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
) (
  input  logic      clk,
  input  logic      reset,
  tug_bar_if.slave  bus
);

  localparam int POS_W = $clog2(NUM_LIGHTS);
  localparam logic [POS_W-1:0] CENTRE = POS_W'((NUM_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0] MAXPOS = POS_W'(NUM_LIGHTS - 1);

  typedef enum logic {PLAY, WIN} state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [1:0]         winner_q, winner_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               prevL_q, prevR_q;

  logic pressL;
  logic pressR;

  // A press is a rising level; holding a key therefore counts only once.
  assign pressL = bus.L & ~prevL_q;
  assign pressR = bus.R & ~prevR_q;

  // State registers. The previous-level registers track the keys on every
  // edge regardless of game state so a key held across a restart is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= PLAY;
      pos_q     <= CENTRE;
      winner_q  <= 2'b00;
      score_l_q <= '0;
      score_r_q <= '0;
      prevL_q   <= 1'b0;
      prevR_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      winner_q  <= winner_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      prevL_q   <= bus.L;
      prevR_q   <= bus.R;
    end
  end

  // Next-state logic. start beats any press on the same edge; simultaneous
  // presses cancel out. A winning press leaves pos where it is.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    winner_d  = winner_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;

    if (bus.start) begin
      state_d  = PLAY;
      pos_d    = CENTRE;
      winner_d = 2'b00;
    end else if (state_q == PLAY) begin
      if (pressL && !pressR) begin
        if (pos_q == MAXPOS) begin
          state_d  = WIN;
          winner_d = 2'b10;
          if (score_l_q != '1) begin
            score_l_d = score_l_q + 1'b1;
          end
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end else if (pressR && !pressL) begin
        if (pos_q == '0) begin
          state_d  = WIN;
          winner_d = 2'b01;
          if (score_r_q != '1) begin
            score_r_d = score_r_q + 1'b1;
          end
        end else begin
          pos_d = pos_q - 1'b1;
        end
      end
    end
  end

  // Display: a single dot while playing, dark once someone has won.
  always_comb begin
    bus.lights = '0;
    if (state_q == PLAY) begin
      bus.lights = NUM_LIGHTS'(1) << pos_q;
    end
  end

  assign bus.winner  = winner_q;
  assign bus.score_l = score_l_q;
  assign bus.score_r = score_r_q;

endmodule

// File: doc/tug_bar.md
TUG_BAR -- requirements
Module: tug_bar

Parameters
REQ-001 SHALL provide NUM_LIGHTS, default 9, number of playfield lights; odd, minimum 3.
REQ-002 SHALL provide SCORE_W, default 3, width of each per-player win counter.

Interface
REQ-003 SHALL have clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have L  input  1  left player key, level, already synchronised to clk.
REQ-006 SHALL have R  input  1  right player key, level, already synchronised to clk.
REQ-007 SHALL have start  input  1  new-round request, level, sampled each clk.
REQ-008 SHALL have lights  output  NUM_LIGHTS  playfield; bit NUM_LIGHTS-1 is the leftmost light.
REQ-009 SHALL have winner  output  2  round result: 00 none, 10 left, 01 right; 11 never driven.
REQ-010 SHALL have score_l  output  SCORE_W  left-player win count.
REQ-011 SHALL have score_r  output  SCORE_W  right-player win count.

Function
REQ-012 SHALL hold a position index pos, range 0..NUM_LIGHTS-1, with centre C = (NUM_LIGHTS-1)/2.
REQ-013 SHALL register the previous L and R levels and define a press as input high now and low on the previous clk edge; a held key yields exactly one press.
REQ-014 SHALL implement the two-state FSM PLAY and WIN.
REQ-015 In PLAY, lights SHALL be one-hot with only bit pos set; in WIN, lights SHALL be all zero.
REQ-016 In PLAY, a left press alone SHALL increment pos at that edge, so lights move one place left on the same edge that samples the press.
REQ-017 In PLAY, a right press alone SHALL decrement pos at that edge.
REQ-018 Simultaneous left and right presses on the same edge SHALL leave pos unchanged.
REQ-019 A left press alone with pos = NUM_LIGHTS-1 SHALL leave pos unchanged, enter WIN, set winner = 10, and increment score_l.
REQ-020 A right press alone with pos = 0 SHALL leave pos unchanged, enter WIN, set winner = 01, and increment score_r.
REQ-021 Scores SHALL saturate at 2^SCORE_W-1 and never wrap.
REQ-022 In WIN, L and R presses SHALL be ignored, and winner and scores SHALL hold.
REQ-023 start high in WIN SHALL, on that edge, enter PLAY with pos = C and winner = 00, keeping scores.
REQ-024 start high in PLAY SHALL set pos = C on that edge, keeping scores.
REQ-025 start SHALL take priority over any press on the same edge; that press is discarded.
REQ-026 Previous-level registers SHALL update every edge in every state, so a key held through a restart generates no press.

Reset
REQ-027 Assertion of reset (low) SHALL immediately, without waiting for clk, force state PLAY, pos = C, winner = 00, scores = 0, and previous-level registers = 0.
REQ-028 While reset is low, lights SHALL show only bit C set.
REQ-029 Reset asserted mid-round or in WIN SHALL discard all state, including scores.
REQ-030 The first clk edge after reset deasserts SHALL treat any key already high as a press.

Verification (NUM_LIGHTS=9, SCORE_W=3)
REQ-031 Bench SHALL apply reset low between clock edges, then observe lights = 9'b000010000, winner = 00, and scores = 0 without any clk edge.
REQ-032 Bench SHALL hold L high for 5 cycles, then observe only one left move: lights = 9'b000100000.
REQ-033 Bench SHALL pulse L and R high on the same edge, then observe lights unchanged.
REQ-034 Bench SHALL give 5 separate L pulses from centre (4 moves, then the win press), then observe lights = 0, winner = 10, score_l = 1; further R pulses change nothing.
REQ-035 Bench SHALL assert start together with an R press while in WIN, then observe lights = 9'b000010000, winner = 00, score_l = 1, and no right move.
REQ-036 Bench SHALL win 9 left rounds, then observe score_l = 7 (saturated); it SHALL then assert reset mid-round and observe score_l = 0.
